// File: rtl/uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_sampler
//
// Timing front end of the UART receiver. It synchronizes the serial line and
// runs the oversampling edge and bit counters. It also takes a majority vote of
// three samples around each bit centre and presents the result as sampled_bit.
//
// Ports:
//   CLK          oversampling clock, rising-edge logic
//   RST          asynchronous, active-high reset
//   RX_IN        raw serial line (asynchronous to CLK, idle high)
//   Prescale     oversampling ratio (even, 4..32), stable while enable=1
//   enable       counters run when high, held cleared when low
//   dat_samp_en  permits sample capture and voting
//   edge_cnt     oversample index within the current bit, 0..Prescale-1
//   bit_cnt      index of the current bit within the frame (wraps)
//   sampled_bit  majority-voted value of the most recent bit
//   sample_valid one-cycle pulse when sampled_bit has just been updated
// -----------------------------------------------------------------------------
module uart_rx_bit_sampler #(
   parameter int unsigned PRESC_W   = 6,
   parameter int unsigned BIT_CNT_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX_IN,
   input  logic [PRESC_W-1:0]   Prescale,
   input  logic                 enable,
   input  logic                 dat_samp_en,
   output logic [PRESC_W-1:0]   edge_cnt,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic                 sampled_bit,
   output logic                 sample_valid
);

   localparam logic [PRESC_W-1:0]   P_ONE = PRESC_W'(1);
   localparam logic [BIT_CNT_W-1:0] B_ONE = BIT_CNT_W'(1);

   // Two-flop synchronizer; the line idles high, so both flops reset to 1.
   logic rx_s1;
   logic rx_s2;

   // The first two votes of the current bit.
   logic s0;
   logic s1;

   logic [PRESC_W-1:0] mid;
   logic [PRESC_W-1:0] samp_lo;
   logic [PRESC_W-1:0] samp_hi;
   logic [PRESC_W-1:0] last_edge;
   logic               wrap;
   logic               samp_ok;
   logic               vote;

   // Sample points M-1, M, M+1 with M = Prescale/2. The wrap test uses >=, so
   // lowering Prescale mid-bit still wraps on the next cycle.
   always_comb begin
      mid       = Prescale >> 1;
      samp_lo   = mid - P_ONE;
      samp_hi   = mid + P_ONE;
      last_edge = Prescale - P_ONE;
      wrap      = (edge_cnt >= last_edge);
      samp_ok   = enable & dat_samp_en;
      vote      = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
   end

   // Synchronizer runs regardless of enable.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= RX_IN;
         rx_s2 <= rx_s1;
      end
   end

   // Edge and bit counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (!enable) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (wrap) begin
         edge_cnt <= '0;
         bit_cnt  <= bit_cnt + B_ONE;
      end else begin
         edge_cnt <= edge_cnt + P_ONE;
      end
   end

   // Sample capture and vote. A skipped capture leaves the stale sample in
   // place. sampled_bit holds between updates, including while enable is low.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s0           <= 1'b1;
         s1           <= 1'b1;
         sampled_bit  <= 1'b1;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (samp_ok) begin
            if (edge_cnt == samp_lo) begin
               s0 <= rx_s2;
            end
            if (edge_cnt == mid) begin
               s1 <= rx_s2;
            end
            if (edge_cnt == samp_hi) begin
               sampled_bit  <= vote;
               sample_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_bit_sampler
//
// Directed testbench for uart_rx_bit_sampler. Inputs are driven 1 time unit
// after each rising edge. Outputs are observed at the same point, so cycle t
// means the state that is visible after the t-th edge following enable.
// -----------------------------------------------------------------------------
module tb_uart_rx_bit_sampler;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       enable;
   logic       dat_samp_en;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       sampled_bit;
   logic       sample_valid;

   int errors;
   int checks;

   uart_rx_bit_sampler #(
      .PRESC_W   (6),
      .BIT_CNT_W (4)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .enable       (enable),
      .dat_samp_en  (dat_samp_en),
      .edge_cnt     (edge_cnt),
      .bit_cnt      (bit_cnt),
      .sampled_bit  (sampled_bit),
      .sample_valid (sample_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      RST = 1'b1; enable = 1'b0; Prescale = 6'd8; dat_samp_en = 1'b1; RX_IN = 1'b0;
      idle(3);
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got edge=%0d bit=%0d sb=%b sv=%b expected 0 0 1 0",
                  edge_cnt, bit_cnt, sampled_bit, sample_valid);
      end
      RST = 1'b0;
      enable = 1'b1;
      // 29 cycles into the frame: edge 5 of bit 3. The line is low, so the vote is 0.
      idle(29);
      checks++;
      if (edge_cnt !== 6'd5 || bit_cnt !== 4'd3 || sampled_bit !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset: got edge=%0d bit=%0d sb=%b expected 5 3 0",
                  edge_cnt, bit_cnt, sampled_bit);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got edge=%0d bit=%0d sb=%b sv=%b expected 0 0 1 0",
                  edge_cnt, bit_cnt, sampled_bit, sample_valid);
      end
      tick();
      RST = 1'b0; enable = 1'b0; RX_IN = 1'b1;
      idle(3);
   endtask

   task automatic test_counters();
      Prescale = 6'd8; dat_samp_en = 1'b1; RX_IN = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         checks++;
         if (edge_cnt !== 6'(k % 8) || bit_cnt !== 4'((k / 8) % 16) ||
             sample_valid !== ((k % 8) == 6 && (k / 8) != 4)) begin
            errors++;
            $display("FAIL counters k=%0d: got edge=%0d bit=%0d sv=%b expected %0d %0d %b",
                     k, edge_cnt, bit_cnt, sample_valid, k % 8, (k / 8) % 16,
                     ((k % 8) == 6 && (k / 8) != 4));
         end
         // Sampling is withheld across the whole of bit 4.
         dat_samp_en = ((k / 8) != 4);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL enable_clear: got edge=%0d bit=%0d expected 0 0", edge_cnt, bit_cnt);
      end
   endtask

   task automatic test_frame();
      logic [9:0] frame;
      int         idx;
      frame = {1'b1, 8'h55, 1'b0};
      Prescale = 6'd16; enable = 1'b0; dat_samp_en = 1'b1; RX_IN = 1'b1;
      idle(3);
      // The line leads the counter by 2 cycles, so rx_s2 is aligned with edge 0.
      for (int t = -2; t < 160; t++) begin
         idx = (t + 2) / 16;
         RX_IN = (idx < 10) ? frame[idx] : 1'b1;
         enable = (t >= 0);
         if (t >= 0 && (t % 16) == 10) begin
            checks++;
            if (sample_valid !== 1'b1 || sampled_bit !== frame[t / 16]) begin
               errors++;
               $display("FAIL frame bit %0d: got sv=%b sb=%b expected 1 %b",
                        t / 16, sample_valid, sampled_bit, frame[t / 16]);
            end
         end
         tick();
      end
   endtask

   task automatic test_glitch();
      int  c;
      logic l;
      Prescale = 6'd8; enable = 1'b0; dat_samp_en = 1'b1; RX_IN = 1'b1;
      idle(3);
      // Intended rx_s2 per cycle: bit 0 low; bit 1 high with a glitch on the
      // edge-4 sample; bit 2 high with a glitch on the edge-3 and edge-4 samples.
      for (int t = -2; t < 24; t++) begin
         c = t + 2;
         if (c < 8)       l = 1'b0;
         else if (c < 16) l = (c == 12) ? 1'b0 : 1'b1;
         else if (c < 24) l = (c == 19 || c == 20) ? 1'b0 : 1'b1;
         else             l = 1'b1;
         RX_IN = l;
         enable = (t >= 0);
         if (t == 6 || t == 14 || t == 22) begin
            checks++;
            if (sample_valid !== 1'b1 || sampled_bit !== (t == 14)) begin
               errors++;
               $display("FAIL glitch t=%0d: got sv=%b sb=%b expected 1 %b",
                        t, sample_valid, sampled_bit, (t == 14));
            end
         end
         tick();
      end
   endtask

   task automatic test_no_sample();
      // sampled_bit is 0 from the last glitch test bit.
      enable = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1;
      tick();
      checks++;
      if (sampled_bit !== 1'b0 || edge_cnt !== 6'd0) begin
         errors++;
         $display("FAIL hold_on_disable: got sb=%b edge=%0d expected 0 0", sampled_bit, edge_cnt);
      end
      enable = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         checks++;
         if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_sample k=%0d: got sv=%b expected 0", k, sample_valid);
         end
      end
      checks++;
      if (sampled_bit !== 1'b0 || bit_cnt !== 4'd3) begin
         errors++;
         $display("FAIL no_sample_hold: got sb=%b bit=%0d expected 0 3", sampled_bit, bit_cnt);
      end
   endtask

   task automatic test_prescale_change();
      enable = 1'b0; dat_samp_en = 1'b0;
      tick();
      Prescale = 6'd32; enable = 1'b1;
      idle(20);
      checks++;
      if (edge_cnt !== 6'd20 || bit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL presc32: got edge=%0d bit=%0d expected 20 0", edge_cnt, bit_cnt);
      end
      Prescale = 6'd8;
      tick();
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) begin
         errors++;
         $display("FAIL presc_wrap: got edge=%0d bit=%0d expected 0 1", edge_cnt, bit_cnt);
      end
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (edge_cnt !== 6'(i % 8) || bit_cnt !== ((i == 8) ? 4'd2 : 4'd1)) begin
            errors++;
            $display("FAIL presc8 i=%0d: got edge=%0d bit=%0d expected %0d %0d",
                     i, edge_cnt, bit_cnt, i % 8, (i == 8) ? 2 : 1);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_counters();
      test_frame();
      test_glitch();
      test_no_sample();
      test_prescale_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
